// File: rtl/ixc_sfifo_dispatch.sv
// ixc_sfifo_dispatch: parses host headers and forwards payload beats through one output register to the sfifo ports.
module ixc_sfifo_dispatch #(
    parameter int               TIDW   = 22,
    parameter int               LENW   = 16,
    parameter logic [TIDW-1:0]  NULLID = {TIDW{1'b1}}
) (
    input  logic             fclk,
    input  logic             GFReset,
    input  logic [511:0]     HiData,
    input  logic             HiValid,
    output logic             HiReady,
    output logic [511:0]     CiData,
    output logic [TIDW-1:0]  CtId,
    output logic             CiValid,
    input  logic             CiReady,
    output logic [15:0]      pktCnt,
    output logic [15:0]      errCnt,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, PAYLOAD, DRAIN} state_t;
    state_t            r_state;
    logic [TIDW-1:0]   r_tid;
    logic [LENW-1:0]   r_rem;
    logic              w_hs;
    logic              w_ds;
    logic              w_last;
    logic [TIDW-1:0]   w_tid;
    logic [LENW-1:0]   w_len;
    assign w_tid  = HiData[TIDW-1:0];
    assign w_len  = HiData[TIDW+LENW-1:TIDW];
    assign w_ds   = CiValid && CiReady;
    assign w_hs   = HiValid && HiReady;
    assign w_last = r_rem == LENW'(1);
    assign busy   = r_state != IDLE;
    // a header is held off while the previous packet's last beat is still outstanding
    always_comb
        HiReady = GFReset ? 1'b0 :
                  r_state == IDLE    ? !CiValid :
                  r_state == PAYLOAD ? (!CiValid || CiReady) : 1'b1;
    always_ff @(posedge fclk) begin
        if (GFReset) begin
            r_state <= IDLE;
            r_tid   <= NULLID;
            r_rem   <= '0;
            CiData  <= '0;
            CtId    <= NULLID;
            CiValid <= 1'b0;
            pktCnt  <= '0;
            errCnt  <= '0;
        end else begin
            if (r_state == PAYLOAD && w_hs) begin
                CiData  <= HiData;
                CtId    <= r_tid;
                CiValid <= 1'b1;
            end else if (w_ds) begin
                CtId    <= NULLID;
                CiValid <= 1'b0;
            end
            if (w_hs) begin
                case (r_state)
                    IDLE: begin
                        if (w_len == '0) begin
                            pktCnt <= pktCnt + 16'd1;
                        end else if (w_tid == NULLID) begin
                            r_state <= DRAIN;
                            r_rem   <= w_len;
                            if (errCnt != 16'hFFFF) errCnt <= errCnt + 16'd1;
                        end else begin
                            r_state <= PAYLOAD;
                            r_tid   <= w_tid;
                            r_rem   <= w_len;
                        end
                    end
                    PAYLOAD: begin
                        r_rem <= r_rem - LENW'(1);
                        if (w_last) begin
                            r_state <= IDLE;
                            pktCnt  <= pktCnt + 16'd1;
                        end
                    end
                    default: begin
                        r_rem <= r_rem - LENW'(1);
                        if (w_last) r_state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ixc_sfifo_dispatch.sv
// tb_ixc_sfifo_dispatch: directed scenario tests for the header/payload dispatcher.
module tb_ixc_sfifo_dispatch;
    localparam logic [21:0] NULLID = 22'h3FFFFF;
    logic         fclk = 1'b0;
    logic         GFReset;
    logic [511:0] HiData;
    logic         HiValid;
    logic         HiReady;
    logic [511:0] CiData;
    logic [21:0]  CtId;
    logic         CiValid;
    logic         CiReady;
    logic [15:0]  pktCnt;
    logic [15:0]  errCnt;
    logic         busy;
    int           checks = 0;
    int           failures = 0;

    ixc_sfifo_dispatch dut (
        .fclk(fclk), .GFReset(GFReset), .HiData(HiData), .HiValid(HiValid), .HiReady(HiReady),
        .CiData(CiData), .CtId(CtId), .CiValid(CiValid), .CiReady(CiReady),
        .pktCnt(pktCnt), .errCnt(errCnt), .busy(busy)
    );

    always #5 fclk = ~fclk;

    function automatic logic [511:0] hdr(input logic [21:0] tid, input logic [15:0] len);
        hdr = {474'd0, len, tid};
    endfunction

    function automatic logic [511:0] dat(input int k);
        logic [31:0] w;
        w = 32'hC0DE0000 + k;
        dat = {16{w}};
    endfunction

    task automatic cyc;
        @(posedge fclk);
        #1;
    endtask

    task automatic test_reset;
        GFReset = 1'b1; HiValid = 1'b1; HiData = hdr(22'd5, 16'd3); CiReady = 1'b1;
        #1;
        checks++; if (HiReady !== 1'b0) begin failures++; $display("FAIL rst_hiready got=%0b exp=0", HiReady); end
        cyc; cyc;
        checks++; if (CiValid !== 1'b0) begin failures++; $display("FAIL rst_civalid got=%0b exp=0", CiValid); end
        checks++; if (CtId !== NULLID) begin failures++; $display("FAIL rst_ctid got=%h exp=%h", CtId, NULLID); end
        checks++; if (CiData !== 512'd0) begin failures++; $display("FAIL rst_cidata got=%h exp=0", CiData[31:0]); end
        checks++; if (pktCnt !== 16'd0 || errCnt !== 16'd0) begin failures++; $display("FAIL rst_counts got=%0d/%0d exp=0/0", pktCnt, errCnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        GFReset = 1'b0; HiValid = 1'b0;
        #1;
        checks++; if (HiReady !== 1'b1) begin failures++; $display("FAIL idle_hiready got=%0b exp=1", HiReady); end
    endtask

    task automatic test_basic;
        CiReady = 1'b1; HiValid = 1'b1; HiData = hdr(22'd5, 16'd3);
        cyc;
        checks++; if (busy !== 1'b1 || CiValid !== 1'b0) begin failures++; $display("FAIL basic_hdr busy=%0b civalid=%0b exp=1/0", busy, CiValid); end
        for (int i = 0; i < 3; i++) begin
            HiData = dat(i);
            #1;
            checks++; if (HiReady !== 1'b1) begin failures++; $display("FAIL basic_hiready%0d got=%0b exp=1", i, HiReady); end
            cyc;
            checks++; if (CiValid !== 1'b1 || CiData !== dat(i) || CtId !== 22'd5) begin failures++; $display("FAIL basic_beat%0d valid=%0b data=%h id=%h exp=1/%h/5", i, CiValid, CiData[31:0], CtId, dat(i) & 512'hFFFFFFFF); end
        end
        HiValid = 1'b0;
        checks++; if (pktCnt !== 16'd1 || busy !== 1'b0) begin failures++; $display("FAIL basic_done pktcnt=%0d busy=%0b exp=1/0", pktCnt, busy); end
        cyc;
        checks++; if (CiValid !== 1'b0 || CtId !== NULLID || CiData !== dat(2)) begin failures++; $display("FAIL basic_after valid=%0b id=%h data=%h exp=0/%h/D2", CiValid, CtId, CiData[31:0], NULLID); end
    endtask

    task automatic test_stall;
        CiReady = 1'b1; HiValid = 1'b1; HiData = hdr(22'd5, 16'd3);
        cyc;
        HiData = dat(10); cyc;
        HiData = dat(11); cyc;
        checks++; if (CiData !== dat(11)) begin failures++; $display("FAIL stall_d1 got=%h exp=D1", CiData[31:0]); end
        CiReady = 1'b0; HiData = dat(12);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (HiReady !== 1'b0) begin failures++; $display("FAIL stall_hiready%0d got=%0b exp=0", i, HiReady); end
            cyc;
            checks++; if (CiValid !== 1'b1 || CiData !== dat(11) || CtId !== 22'd5) begin failures++; $display("FAIL stall_hold%0d valid=%0b data=%h id=%h", i, CiValid, CiData[31:0], CtId); end
        end
        CiReady = 1'b1;
        #1;
        checks++; if (HiReady !== 1'b1) begin failures++; $display("FAIL stall_release got=%0b exp=1", HiReady); end
        cyc;
        HiValid = 1'b0;
        checks++; if (CiData !== dat(12) || CiValid !== 1'b1 || pktCnt !== 16'd2) begin failures++; $display("FAIL stall_d2 data=%h valid=%0b pktcnt=%0d exp=D2/1/2", CiData[31:0], CiValid, pktCnt); end
        cyc;
        checks++; if (CiValid !== 1'b0) begin failures++; $display("FAIL stall_end got=%0b exp=0", CiValid); end
    endtask

    task automatic test_len0;
        CiReady = 1'b1; HiValid = 1'b1; HiData = hdr(22'd9, 16'd0);
        cyc;
        checks++; if (busy !== 1'b0 || pktCnt !== 16'd3 || CiValid !== 1'b0) begin failures++; $display("FAIL len0 busy=%0b pktcnt=%0d valid=%0b exp=0/3/0", busy, pktCnt, CiValid); end
        HiData = hdr(22'd9, 16'd1);
        cyc;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL len0_next busy=%0b exp=1", busy); end
        HiData = dat(20);
        cyc;
        HiValid = 1'b0;
        checks++; if (CiValid !== 1'b1 || CtId !== 22'd9 || pktCnt !== 16'd4) begin failures++; $display("FAIL len0_beat valid=%0b id=%h pktcnt=%0d exp=1/9/4", CiValid, CtId, pktCnt); end
        cyc;
    endtask

    task automatic test_drain;
        CiReady = 1'b1; HiValid = 1'b1; HiData = hdr(NULLID, 16'd2);
        cyc;
        checks++; if (busy !== 1'b1 || errCnt !== 16'd1 || CiValid !== 1'b0) begin failures++; $display("FAIL drain_hdr busy=%0b errcnt=%0d valid=%0b exp=1/1/0", busy, errCnt, CiValid); end
        for (int i = 0; i < 2; i++) begin
            HiData = dat(30 + i);
            #1;
            checks++; if (HiReady !== 1'b1) begin failures++; $display("FAIL drain_hiready%0d got=%0b exp=1", i, HiReady); end
            cyc;
            checks++; if (CiValid !== 1'b0) begin failures++; $display("FAIL drain_valid%0d got=%0b exp=0", i, CiValid); end
        end
        checks++; if (busy !== 1'b0 || pktCnt !== 16'd4) begin failures++; $display("FAIL drain_done busy=%0b pktcnt=%0d exp=0/4", busy, pktCnt); end
        HiData = hdr(22'd7, 16'd1); cyc;
        HiData = dat(40); cyc;
        HiValid = 1'b0;
        checks++; if (CiValid !== 1'b1 || CtId !== 22'd7 || CiData !== dat(40) || pktCnt !== 16'd5) begin failures++; $display("FAIL drain_next valid=%0b id=%h pktcnt=%0d exp=1/7/5", CiValid, CtId, pktCnt); end
        cyc;
    endtask

    task automatic test_mid_reset;
        CiReady = 1'b1; HiValid = 1'b1; HiData = hdr(22'd4, 16'd3);
        cyc;
        HiData = dat(50); cyc;
        checks++; if (CiValid !== 1'b1 || CtId !== 22'd4) begin failures++; $display("FAIL mrst_beat valid=%0b id=%h exp=1/4", CiValid, CtId); end
        GFReset = 1'b1; HiData = dat(51);
        #1;
        checks++; if (HiReady !== 1'b0) begin failures++; $display("FAIL mrst_hiready got=%0b exp=0", HiReady); end
        cyc;
        GFReset = 1'b0;
        checks++; if (CiValid !== 1'b0 || busy !== 1'b0 || pktCnt !== 16'd0 || CtId !== NULLID) begin failures++; $display("FAIL mrst_state valid=%0b busy=%0b pktcnt=%0d id=%h", CiValid, busy, pktCnt, CtId); end
        HiData = hdr(22'd6, 16'd1); cyc;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mrst_hdr busy=%0b exp=1", busy); end
        HiData = dat(52); cyc;
        HiValid = 1'b0;
        checks++; if (CtId !== 22'd6 || CiData !== dat(52) || pktCnt !== 16'd1) begin failures++; $display("FAIL mrst_next id=%h pktcnt=%0d exp=6/1", CtId, pktCnt); end
        cyc;
    endtask

    task automatic test_back_to_back;
        CiReady = 1'b1; HiValid = 1'b1; HiData = hdr(22'd1, 16'd1);
        cyc;
        HiData = dat(60); cyc;
        checks++; if (CtId !== 22'd1 || CiValid !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL b2b_first id=%h valid=%0b busy=%0b exp=1/1/0", CtId, CiValid, busy); end
        HiData = hdr(22'd2, 16'd1);
        #1;
        checks++; if (HiReady !== 1'b0) begin failures++; $display("FAIL b2b_holdoff got=%0b exp=0", HiReady); end
        cyc;
        checks++; if (CiValid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL b2b_consumed valid=%0b busy=%0b exp=0/0", CiValid, busy); end
        checks++; if (HiReady !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%0b exp=1", HiReady); end
        cyc;
        HiData = dat(61); cyc;
        HiValid = 1'b0;
        checks++; if (CtId !== 22'd2 || CiData !== dat(61) || pktCnt !== 16'd3) begin failures++; $display("FAIL b2b_second id=%h pktcnt=%0d exp=2/3", CtId, pktCnt); end
        cyc;
    endtask

    initial begin
        HiData = '0; HiValid = 1'b0; CiReady = 1'b0; GFReset = 1'b1;
        test_reset;
        test_basic;
        test_stall;
        test_len0;
        test_drain;
        test_mid_reset;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
